regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register bank. It grants requesters A and B round-robin,
// registers one commit per cycle, and keeps a pending-destination scoreboard.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [4:0]        a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [4:0]        b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              iss_valid,
    input  logic [4:0]        iss_rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic              hazard,
    output logic              RegWen,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] wb_out,
    output logic [5:0]        pend_cnt
);

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 6;

    logic              r_last_b;
    logic [NREG-1:0]   r_pend;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_xfer;
    logic [AW-1:0]     w_rd;
    logic [DATA_W-1:0] w_data;
    logic [NREG-1:0]   w_pend_nxt;
    logic [CW-1:0]     w_cnt_nxt;

    // On a tie, the requester that was not granted last wins. Nothing is granted during reset.
    assign w_grant_a = !rst && a_valid && (!b_valid || r_last_b);
    assign w_grant_b = !rst && b_valid && (!a_valid || !r_last_b);
    assign w_xfer    = w_grant_a || w_grant_b;
    assign w_rd      = w_grant_a ? a_rd   : b_rd;
    assign w_data    = w_grant_a ? a_data : b_data;

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    // The hazard check reads only the current pending vector, so a commit in flight is not bypassed.
    assign hazard = ((rs1 != '0) && r_pend[rs1]) || ((rs2 != '0) && r_pend[rs2]);

    // A commit clears its register first and an issue sets one after it, so an issue to the same register wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (RegWen) begin
            w_pend_nxt[rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            w_pend_nxt[iss_rd] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b <= 1'b1;
            r_pend   <= '0;
            pend_cnt <= '0;
            RegWen   <= 1'b0;
            rd       <= '0;
            wb_out   <= '0;
        end else begin
            r_pend   <= w_pend_nxt;
            pend_cnt <= w_cnt_nxt;
            RegWen   <= w_xfer && (w_rd != '0);
            if (w_xfer) begin
                rd       <= w_rd;
                wb_out   <= w_data;
                r_last_b <= w_grant_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. It runs a directed vector table, hand-written reset and fill
// sequences, and random traffic checked against a reference model.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, iss_valid;
    logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, hazard, RegWen;
    logic [4:0]  rd;
    logic [31:0] wb_out;
    logic [5:0]  pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(.DATA_W(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .RegWen(RegWen), .rd(rd), .wb_out(wb_out), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the architectural view of the block.
    bit          m_pend [32];
    bit          m_last_b;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns the granted requester: -1 for none, 0 for A, 1 for B.
    function automatic int winner();
        if (rst) return -1;
        if (a_valid && b_valid) return m_last_b ? 0 : 1;
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        foreach (m_pend[i]) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_check();
        int  w;
        bit  hz;
        w  = winner();
        hz = (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]);
        chk("rnd_a_ready", 32'(a_ready), 32'(w == 0));
        chk("rnd_b_ready", 32'(b_ready), 32'(w == 1));
        chk("rnd_hazard", 32'(hazard), 32'(hz));
        chk("rnd_RegWen", 32'(RegWen), 32'(m_wen));
        chk("rnd_pend_cnt", 32'(pend_cnt), 32'(model_cnt()));
        if (m_wen) begin
            chk("rnd_rd", 32'(rd), 32'(m_rd));
            chk("rnd_wb_out", wb_out, m_data);
        end
    endtask

    task automatic model_update();
        int w;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_last_b = 1'b1;
            m_wen    = 1'b0;
            m_rd     = '0;
            m_data   = '0;
        end else begin
            w = winner();
            if (m_wen) m_pend[m_rd] = 1'b0;
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            m_wen = (w >= 0) && ((w == 0 ? a_rd : b_rd) != 0);
            if (w >= 0) begin
                m_rd     = (w == 0) ? a_rd : b_rd;
                m_data   = (w == 0) ? a_data : b_data;
                m_last_b = (w == 1);
            end
        end
    endtask

    task automatic step(input bit do_chk);
        if (do_chk) model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    typedef struct {
        logic        rst;
        logic        av;  logic [4:0] ard; logic [31:0] adat;
        logic        bv;  logic [4:0] brd; logic [31:0] bdat;
        logic        iv;  logic [4:0] ird;
        logic [4:0]  r1;  logic [4:0] r2;
        logic        ea;  logic eb; logic ehz; logic ewen;
        logic [4:0]  erd; logic [31:0] edat; logic [5:0] ecnt;
    } vec_t;

    function automatic vec_t mk(
        input logic rst_i, input logic av, input logic [4:0] ard, input logic [31:0] adat,
        input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
        input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
        input logic ea, input logic eb, input logic ehz, input logic ewen,
        input logic [4:0] erd, input logic [31:0] edat, input logic [5:0] ecnt);
        vec_t v;
        v.rst = rst_i; v.av = av; v.ard = ard; v.adat = adat; v.bv = bv; v.brd = brd; v.bdat = bdat;
        v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
        v.ea = ea; v.eb = eb; v.ehz = ehz; v.ewen = ewen; v.erd = erd; v.edat = edat; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        // Each row's expectations are sampled after its inputs settle and before its clock edge.
        //          rst av ard adat          bv brd bdat   iv ird r1 r2 | ea eb hz wen rd  data   cnt
        tbl[0]  = mk(1, 1, 3, 32'h99,        0, 0, 0,      0, 0, 0, 0,   0, 0, 0, 0, 0, 0,      0);
        tbl[1]  = mk(0, 1, 3, 32'h11,        1, 4, 32'h22, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,      0);
        tbl[2]  = mk(0, 1, 3, 32'h11,        1, 4, 32'h22, 0, 0, 0, 0,   0, 1, 0, 1, 3, 32'h11, 0);
        tbl[3]  = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 0, 0,   0, 0, 0, 1, 4, 32'h22, 0);
        tbl[4]  = mk(0, 1, 0, 32'hFFFFFFFF,  0, 0, 0,      0, 0, 0, 0,   1, 0, 0, 0, 0, 0,      0);
        tbl[5]  = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 0, 0,   0, 0, 0, 0, 0, 0,      0);
        tbl[6]  = mk(0, 0, 0, 0,             0, 0, 0,      1, 5, 0, 0,   0, 0, 0, 0, 0, 0,      0);
        tbl[7]  = mk(0, 0, 0, 0,             1, 5, 32'h55, 0, 0, 5, 0,   0, 1, 1, 0, 0, 0,      1);
        tbl[8]  = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 5, 0,   0, 0, 1, 1, 5, 32'h55, 1);
        tbl[9]  = mk(0, 0, 0, 0,             0, 0, 0,      1, 7, 5, 0,   0, 0, 0, 0, 0, 0,      0);
        tbl[10] = mk(0, 1, 7, 32'h77,        0, 0, 0,      0, 0, 0, 7,   1, 0, 1, 0, 0, 0,      1);
        tbl[11] = mk(0, 0, 0, 0,             0, 0, 0,      1, 7, 0, 7,   0, 0, 1, 1, 7, 32'h77, 1);
        tbl[12] = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 0, 7,   0, 0, 1, 0, 0, 0,      1);
        tbl[13] = mk(0, 1, 3, 32'h13,        1, 4, 32'h24, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0,      1);
        tbl[14] = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 0, 0,   0, 0, 0, 1, 4, 32'h24, 1);

        idle_inputs();
        rst = 1;
        #1; step(0);
        step(0);

        // Directed table
        foreach (tbl[k]) begin
            rst = tbl[k].rst;
            a_valid = tbl[k].av; a_rd = tbl[k].ard; a_data = tbl[k].adat;
            b_valid = tbl[k].bv; b_rd = tbl[k].brd; b_data = tbl[k].bdat;
            iss_valid = tbl[k].iv; iss_rd = tbl[k].ird; rs1 = tbl[k].r1; rs2 = tbl[k].r2;
            #1;
            chk($sformatf("tbl%0d_a_ready", k), 32'(a_ready), 32'(tbl[k].ea));
            chk($sformatf("tbl%0d_b_ready", k), 32'(b_ready), 32'(tbl[k].eb));
            chk($sformatf("tbl%0d_hazard", k), 32'(hazard), 32'(tbl[k].ehz));
            chk($sformatf("tbl%0d_RegWen", k), 32'(RegWen), 32'(tbl[k].ewen));
            chk($sformatf("tbl%0d_pend_cnt", k), 32'(pend_cnt), 32'(tbl[k].ecnt));
            if (tbl[k].ewen) begin
                chk($sformatf("tbl%0d_rd", k), 32'(rd), 32'(tbl[k].erd));
                chk($sformatf("tbl%0d_wb_out", k), wb_out, tbl[k].edat);
            end
            step(0);
        end

        // Reset in the middle of operation
        idle_inputs(); rst = 1; #1; step(0);
        idle_inputs(); iss_valid = 1; iss_rd = 2; #1; step(0);
        iss_rd = 9; #1; step(0);
        idle_inputs(); a_valid = 1; a_rd = 2; a_data = 32'hAB; #1;
        chk("mid_a_ready", 32'(a_ready), 32'd1);
        chk("mid_cnt_before", 32'(pend_cnt), 32'd2);
        step(0);
        rst = 1; b_valid = 1; b_rd = 6; #1;
        chk("mid_rst_RegWen_inflight", 32'(RegWen), 32'd1);
        chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_b_ready", 32'(b_ready), 32'd0);
        step(0);
        idle_inputs(); a_valid = 1; a_rd = 3; a_data = 32'h3; b_valid = 1; b_rd = 4; b_data = 32'h4; rs1 = 2; #1;
        chk("mid_post_RegWen", 32'(RegWen), 32'd0);
        chk("mid_post_cnt", 32'(pend_cnt), 32'd0);
        chk("mid_post_hazard", 32'(hazard), 32'd0);
        chk("mid_post_tie_a", 32'(a_ready), 32'd1);
        chk("mid_post_tie_b", 32'(b_ready), 32'd0);
        step(0);
        idle_inputs(); #1;
        chk("mid_post_commit_wen", 32'(RegWen), 32'd1);
        chk("mid_post_commit_rd", 32'(rd), 32'd3);
        step(0);

        // Fill every destination register
        idle_inputs(); rst = 1; #1; step(0);
        idle_inputs();
        for (int r = 1; r < 32; r++) begin
            iss_valid = 1; iss_rd = 5'(r); #1; step(0);
        end
        iss_rd = 0; #1; step(0);
        iss_rd = 5; #1; step(0);
        idle_inputs(); #1;
        chk("fill_cnt", 32'(pend_cnt), 32'd31);
        for (int r = 1; r < 32; r++) begin
            rs1 = 5'(r); #1;
            chk($sformatf("fill_hazard_rs1_%0d", r), 32'(hazard), 32'd1);
        end
        rs1 = 0; rs2 = 0; #1;
        chk("fill_hazard_zero", 32'(hazard), 32'd0);
        step(0);

        // Random traffic against the model
        idle_inputs(); rst = 1; #1; step(0);
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            a_valid   = 1'($urandom_range(0, 1));
            a_rd      = 5'($urandom_range(0, 7));
            a_data    = $urandom;
            b_valid   = 1'($urandom_range(0, 1));
            b_rd      = 5'($urandom_range(0, 7));
            b_data    = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 7));
            rs2       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            #1;
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
